stream_cosim_comparator: RTL and testbench

//  Clocked, parametrised successor of the buffered two-channel cosim checker.
//  - Accepts a gold stream and a DUT stream over valid/ready. Buffers each in its own DEPTH-entry FIFO.
//  - Pops one token from each side in lockstep and compares them under a bit mask.
//  - Keeps saturating match/mismatch counters and captures the first mismatch.
//  - Flags a timeout if the streams drift apart.
//  - Sits at the output of every ALU channel (Y, Z, ...) in the synthesizable cosim harness.

---
 rtl/stream_cosim_comparator.sv | 147 ++++++++++++++
 tb/tb_stream_cosim_comparator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_cosim_comparator.sv
// rtl/stream_cosim_comparator.sv - dual-FIFO gold/DUT token comparator with counters, first-mismatch capture and stall timeout
module stream_cosim_comparator #(
    parameter int            W           = 16,
    parameter int            DEPTH       = 8,
    parameter int            CNT_W       = 16,
    parameter logic [W-1:0]  MASK        = '1,
    parameter int            TIMEOUT_CYC = 300,
    parameter int            STOP_ON_ERR = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             GOLD_VALID,
    output logic             GOLD_READY,
    input  logic [W-1:0]     GOLD_DATA,
    input  logic             DUT_VALID,
    output logic             DUT_READY,
    input  logic [W-1:0]     DUT_DATA,
    output logic             CMP_VALID,
    output logic             CMP_MATCH,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic [CNT_W-1:0] MISMATCH_CNT,
    output logic             ERR,
    output logic [W-1:0]     FIRST_GOLD,
    output logic [W-1:0]     FIRST_DUT,
    output logic [CNT_W-1:0] FIRST_IDX,
    output logic             TIMEOUT,
    output logic             HALTED
);

    localparam int AW   = $clog2(DEPTH);
    localparam int ST_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [ST_W-1:0] STALL_LIMIT = ST_W'(TIMEOUT_CYC);
    localparam logic [AW:0]     FULL_CNT    = (AW + 1)'(DEPTH);
    localparam logic [0:0]      S_RUN       = 1'b0;
    localparam logic [0:0]      S_HALT      = 1'b1;

    logic [0:0]      state;
    logic [W-1:0]    g_mem [DEPTH];
    logic [W-1:0]    d_mem [DEPTH];
    logic [AW-1:0]   g_wr, g_rd, d_wr, d_rd;
    logic [AW:0]     g_cnt, d_cnt;
    logic            g_empty, d_empty, g_full, d_full;
    logic            g_push, d_push, pop, mism;
    logic [W-1:0]    g_head, d_head;
    logic [CNT_W-1:0] cmp_idx;
    logic [ST_W-1:0] stall;

    assign g_empty = (g_cnt == '0);
    assign d_empty = (d_cnt == '0);
    assign g_full  = (g_cnt == FULL_CNT);
    assign d_full  = (d_cnt == FULL_CNT);
    assign HALTED  = (state == S_HALT);

    // READY looks only at occupancy, so a full FIFO never takes a token even when it pops this cycle
    assign GOLD_READY = !g_full && (state == S_RUN);
    assign DUT_READY  = !d_full && (state == S_RUN);
    assign g_push     = GOLD_VALID && GOLD_READY;
    assign d_push     = DUT_VALID && DUT_READY;
    assign pop        = !g_empty && !d_empty && (state == S_RUN);

    assign g_head = g_mem[g_rd];
    assign d_head = d_mem[d_rd];
    assign mism   = |((g_head ^ d_head) & MASK);

    always_ff @(posedge CLK) begin
        if (g_push) g_mem[g_wr] <= GOLD_DATA;
        if (d_push) d_mem[d_wr] <= DUT_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            g_wr  <= '0;
            g_rd  <= '0;
            g_cnt <= '0;
            d_wr  <= '0;
            d_rd  <= '0;
            d_cnt <= '0;
        end else begin
            if (g_push) g_wr <= g_wr + AW'(1);
            if (d_push) d_wr <= d_wr + AW'(1);
            if (pop) begin
                g_rd <= g_rd + AW'(1);
                d_rd <= d_rd + AW'(1);
            end
            case ({g_push, pop})
                2'b10:   g_cnt <= g_cnt + (AW + 1)'(1);
                2'b01:   g_cnt <= g_cnt - (AW + 1)'(1);
                default: g_cnt <= g_cnt;
            endcase
            case ({d_push, pop})
                2'b10:   d_cnt <= d_cnt + (AW + 1)'(1);
                2'b01:   d_cnt <= d_cnt - (AW + 1)'(1);
                default: d_cnt <= d_cnt;
            endcase
        end
    end

    // Counters and first-mismatch capture update on the pop edge so they are visible alongside CMP_VALID
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_RUN;
            CMP_VALID    <= 1'b0;
            CMP_MATCH    <= 1'b0;
            MATCH_CNT    <= '0;
            MISMATCH_CNT <= '0;
            ERR          <= 1'b0;
            FIRST_GOLD   <= '0;
            FIRST_DUT    <= '0;
            FIRST_IDX    <= '0;
            cmp_idx      <= '0;
        end else begin
            CMP_VALID <= pop;
            CMP_MATCH <= pop && !mism;
            if (pop) begin
                if (!mism) begin
                    if (MATCH_CNT != '1) MATCH_CNT <= MATCH_CNT + CNT_W'(1);
                end else begin
                    if (MISMATCH_CNT != '1) MISMATCH_CNT <= MISMATCH_CNT + CNT_W'(1);
                    if (!ERR) begin
                        ERR        <= 1'b1;
                        FIRST_GOLD <= g_head;
                        FIRST_DUT  <= d_head;
                        FIRST_IDX  <= cmp_idx;
                    end
                    if (STOP_ON_ERR != 0) state <= S_HALT;
                end
                if (cmp_idx != '1) cmp_idx <= cmp_idx + CNT_W'(1);
            end
        end
    end

    // Stall counts cycles where exactly one side holds tokens; balanced or idle streams clear it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall   <= '0;
            TIMEOUT <= 1'b0;
        end else if (state == S_RUN) begin
            if (g_empty ^ d_empty) begin
                if (stall != '1) stall <= stall + ST_W'(1);
            end else begin
                stall <= '0;
            end
            if ((TIMEOUT_CYC != 0) && (stall == STALL_LIMIT)) TIMEOUT <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_cosim_comparator.sv
// tb/tb_stream_cosim_comparator.sv - scoreboard bench for stream_cosim_comparator (default and masked/stop-on-error instances)
module tb_stream_cosim_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        gv [2];
    logic        dv [2];
    logic [15:0] gd [2];
    logic [15:0] dd [2];
    logic        gr [2];
    logic        dr [2];
    logic        cv [2];
    logic        cm [2];
    logic        err [2];
    logic        to [2];
    logic        hl [2];
    logic [15:0] mc [2];
    logic [15:0] mmc [2];
    logic [15:0] fg [2];
    logic [15:0] fd [2];
    logic [15:0] fi [2];

    int n_chk = 0;
    int n_err = 0;
    bit q0 [$];
    bit q1 [$];

    always #5 clk = ~clk;

    stream_cosim_comparator u_dut (
        .CLK(clk), .RESET(rst),
        .GOLD_VALID(gv[0]), .GOLD_READY(gr[0]), .GOLD_DATA(gd[0]),
        .DUT_VALID(dv[0]), .DUT_READY(dr[0]), .DUT_DATA(dd[0]),
        .CMP_VALID(cv[0]), .CMP_MATCH(cm[0]),
        .MATCH_CNT(mc[0]), .MISMATCH_CNT(mmc[0]), .ERR(err[0]),
        .FIRST_GOLD(fg[0]), .FIRST_DUT(fd[0]), .FIRST_IDX(fi[0]),
        .TIMEOUT(to[0]), .HALTED(hl[0])
    );

    stream_cosim_comparator #(.MASK(16'hFFFE), .STOP_ON_ERR(1)) u_alt (
        .CLK(clk), .RESET(rst),
        .GOLD_VALID(gv[1]), .GOLD_READY(gr[1]), .GOLD_DATA(gd[1]),
        .DUT_VALID(dv[1]), .DUT_READY(dr[1]), .DUT_DATA(dd[1]),
        .CMP_VALID(cv[1]), .CMP_MATCH(cm[1]),
        .MATCH_CNT(mc[1]), .MISMATCH_CNT(mmc[1]), .ERR(err[1]),
        .FIRST_GOLD(fg[1]), .FIRST_DUT(fd[1]), .FIRST_IDX(fi[1]),
        .TIMEOUT(to[1]), .HALTED(hl[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every CMP_VALID pops one expected match bit
    always @(negedge clk) begin
        if (cv[0]) begin
            n_chk++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL i0_unexpected_cmp: got CMP_VALID=1 expected no compare");
            end else if (cm[0] !== q0.pop_front()) begin
                n_err++;
                $display("FAIL i0_cmp_match: got %0b expected %0b", cm[0], !cm[0]);
            end
        end
        if (cv[1]) begin
            n_chk++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL i1_unexpected_cmp: got CMP_VALID=1 expected no compare");
            end else if (cm[1] !== q1.pop_front()) begin
                n_err++;
                $display("FAIL i1_cmp_match: got %0b expected %0b", cm[1], !cm[1]);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            gv[s] = 1'b0; dv[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset(input int s);
        @(negedge clk);
        check($sformatf("i%0d_rst_gold_ready", s), 32'(gr[s]), 1);
        check($sformatf("i%0d_rst_dut_ready", s), 32'(dr[s]), 1);
        check($sformatf("i%0d_rst_cmp_valid", s), 32'(cv[s]), 0);
        check($sformatf("i%0d_rst_cmp_match", s), 32'(cm[s]), 0);
        check($sformatf("i%0d_rst_match_cnt", s), 32'(mc[s]), 0);
        check($sformatf("i%0d_rst_mismatch_cnt", s), 32'(mmc[s]), 0);
        check($sformatf("i%0d_rst_err", s), 32'(err[s]), 0);
        check($sformatf("i%0d_rst_first_gold", s), 32'(fg[s]), 0);
        check($sformatf("i%0d_rst_first_dut", s), 32'(fd[s]), 0);
        check($sformatf("i%0d_rst_first_idx", s), 32'(fi[s]), 0);
        check($sformatf("i%0d_rst_timeout", s), 32'(to[s]), 0);
        check($sformatf("i%0d_rst_halted", s), 32'(hl[s]), 0);
    endtask

    // Presents a pair on both sides until both are accepted; call at posedge+1
    task automatic push_pair(input int s, input logic [15:0] g, input logic [15:0] d,
                             input bit expect_cmp, input bit m);
        int n = 0;
        gv[s] = 1'b1; gd[s] = g; dv[s] = 1'b1; dd[s] = d;
        @(negedge clk);
        while (!(gr[s] && dr[s]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++; n_err++;
            $display("FAIL i%0d_pair_accept: got no READY expected READY within 50 cycles", s);
        end
        @(posedge clk); #1;
        gv[s] = 1'b0; dv[s] = 1'b0;
        if (expect_cmp) begin
            if (s == 0) q0.push_back(m);
            else        q1.push_back(m);
        end
    endtask

    task automatic push_one(input int s, input bit dut_side, input logic [15:0] v);
        int n = 0;
        if (dut_side) begin dv[s] = 1'b1; dd[s] = v; end
        else          begin gv[s] = 1'b1; gd[s] = v; end
        @(negedge clk);
        while (!(dut_side ? dr[s] : gr[s]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++; n_err++;
            $display("FAIL i%0d_single_accept: got no READY expected READY within 50 cycles", s);
        end
        @(posedge clk); #1;
        if (dut_side) dv[s] = 1'b0;
        else          gv[s] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            gv[s] = 1'b0; dv[s] = 1'b0; gd[s] = '0; dd[s] = '0;
        end
        do_reset();
        check_reset(0);
        check_reset(1);

        // Equal pairs, first one also measures push-to-compare latency
        @(posedge clk); #1;
        push_pair(0, 16'h0011, 16'h0011, 1'b1, 1'b1);
        @(negedge clk);
        check("lat_cycle1_no_cmp", 32'(cv[0]), 0);
        @(negedge clk);
        check("lat_cycle2_cmp", 32'(cv[0]), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_pair(0, 16'h0022 + 16'(i), 16'h0022 + 16'(i), 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t1_match_cnt", 32'(mc[0]), 5);
        check("t1_mismatch_cnt", 32'(mmc[0]), 0);
        check("t1_err", 32'(err[0]), 0);

        // Single-bit mismatch: full mask reports it, bit0-masked instance matches
        do_reset();
        push_pair(0, 16'h1234, 16'h1235, 1'b1, 1'b0);
        push_pair(1, 16'h1234, 16'h1235, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t2_mismatch_cnt", 32'(mmc[0]), 1);
        check("t2_err", 32'(err[0]), 1);
        check("t2_first_gold", 32'(fg[0]), 'h1234);
        check("t2_first_dut", 32'(fd[0]), 'h1235);
        check("t2_first_idx", 32'(fi[0]), 0);
        check("t2_mask_match_cnt", 32'(mc[1]), 1);
        check("t2_mask_err", 32'(err[1]), 0);
        @(posedge clk); #1;
        push_pair(0, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t2_second_mismatch_cnt", 32'(mmc[0]), 2);
        check("t2_first_gold_kept", 32'(fg[0]), 'h1234);
        check("t2_first_idx_kept", 32'(fi[0]), 0);

        // Stop-on-error: third pair differs in bit1
        do_reset();
        push_pair(1, 16'h0001, 16'h0001, 1'b1, 1'b1);
        push_pair(1, 16'h0002, 16'h0002, 1'b1, 1'b1);
        push_pair(1, 16'h0300, 16'h0302, 1'b1, 1'b0);
        push_pair(1, 16'h0004, 16'h0004, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_halted", 32'(hl[1]), 1);
        check("t4_gold_ready", 32'(gr[1]), 0);
        check("t4_dut_ready", 32'(dr[1]), 0);
        check("t4_match_cnt", 32'(mc[1]), 2);
        check("t4_mismatch_cnt", 32'(mmc[1]), 1);
        check("t4_first_idx", 32'(fi[1]), 2);
        check("t4_first_dut", 32'(fd[1]), 'h0302);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_match_cnt_frozen", 32'(mc[1]), 2);
        check("t4_still_halted", 32'(hl[1]), 1);

        // Gold fills its FIFO while DUT idles, then timeout, then DUT catches up
        do_reset();
        for (int i = 0; i < 8; i++) push_one(0, 1'b0, 16'h0100 + 16'(i));
        @(negedge clk);
        check("t3_gold_full_ready", 32'(gr[0]), 0);
        check("t3_dut_ready", 32'(dr[0]), 1);
        repeat (280) @(posedge clk);
        @(negedge clk);
        check("t3_no_timeout_yet", 32'(to[0]), 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t3_timeout", 32'(to[0]), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(1'b1);
            push_one(0, 1'b1, 16'h0100 + 16'(i));
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t3_match_cnt", 32'(mc[0]), 8);
        check("t3_gold_ready_again", 32'(gr[0]), 1);
        check("t3_timeout_sticky", 32'(to[0]), 1);

        // Full gold FIFO popping while a 9th gold token waits: no pass-through
        do_reset();
        for (int i = 0; i < 8; i++) push_one(0, 1'b0, 16'h5000 + 16'(i));
        for (int i = 0; i < 9; i++) q0.push_back(1'b1);
        gv[0] = 1'b1; gd[0] = 16'h5008; dv[0] = 1'b1; dd[0] = 16'h5000;
        @(posedge clk); #1;
        dd[0] = 16'h5001;
        @(negedge clk);
        check("t5_full_pop_no_passthru", 32'(gr[0]), 0);
        @(posedge clk); #1;
        dd[0] = 16'h5002;
        @(negedge clk);
        check("t5_ready_after_pop", 32'(gr[0]), 1);
        @(posedge clk); #1;
        gv[0] = 1'b0;
        for (int i = 3; i < 9; i++) begin
            dd[0] = 16'h5000 + 16'(i);
            @(posedge clk); #1;
        end
        dv[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t5_match_cnt", 32'(mc[0]), 9);
        check("t5_mismatch_cnt", 32'(mmc[0]), 0);

        // Reset with 4 gold tokens buffered: they must vanish
        do_reset();
        for (int i = 0; i < 4; i++) push_one(0, 1'b0, 16'h0700 + 16'(i));
        do_reset();
        check_reset(0);
        @(posedge clk); #1;
        push_one(0, 1'b1, 16'h0700);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t6_match_cnt", 32'(mc[0]), 0);
        check("t6_mismatch_cnt", 32'(mmc[0]), 0);

        check("i0_scoreboard_drained", 32'(q0.size()), 0);
        check("i1_scoreboard_drained", 32'(q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
